// File: rtl/piece_shift_engine_if.sv
// Handshake and data bundle between the game FSM (master) and the piece shift engine (slave).
interface piece_shift_engine_if #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int COL_W   = 6,
  parameter int ROW_W   = 6
);
  logic                         move_left;
  logic                         move_right;
  logic                         tick;
  logic                         start;
  logic [15:0]                  piece_mask;
  logic [ROW_W-1:0]             anchor_row;
  logic signed [COL_W-1:0]      anchor_col;
  logic [BOARD_W*BOARD_H-1:0]   blocks_exist;
  logic                         busy;
  logic                         done;
  logic                         moved;
  logic                         blocked;
  logic signed [COL_W-1:0]      loc_col_out;

  modport master (
    output move_left, move_right, tick, start, piece_mask, anchor_row, anchor_col, blocks_exist,
    input  busy, done, moved, blocked, loc_col_out
  );

  modport slave (
    input  move_left, move_right, tick, start, piece_mask, anchor_row, anchor_col, blocks_exist,
    output busy, done, moved, blocked, loc_col_out
  );
endinterface

// File: rtl/piece_shift_engine.sv
// Horizontal move engine: latches left/right requests, checks the shifted 4x4 mask row by row.
// Optional auto-repeat on held buttons is enabled by defining PIECE_SHIFT_AUTOREPEAT_EN.
module piece_shift_engine #(
  parameter int BOARD_W      = 10,
  parameter int BOARD_H      = 20,
  parameter int COL_W        = 6,
  parameter int ROW_W        = 6,
  parameter int SPAWN_COL    = 3,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input logic                clk,
  input logic                rst_n,
  piece_shift_engine_if.slave io_bus
);

  localparam int CellN = BOARD_W * BOARD_H;
  localparam int IdxW  = $clog2(CellN);

  typedef enum logic [1:0] {StIdle, StCheck, StCommit} state_e;

  state_e                  r_state, w_state_next;
  logic [1:0]              r_row;
  logic                    r_fail;
  logic                    r_dir_left;
  logic [15:0]             r_mask;
  logic [ROW_W-1:0]        r_anchor_row;
  logic signed [COL_W-1:0] r_anchor_col;
  logic                    r_req_l, r_req_r;
  logic                    r_busy, r_done, r_moved, r_blocked;
  logic signed [COL_W-1:0] r_loc_col;

  logic                    w_busy_d, w_done_d, w_moved_d, w_blocked_d;
  logic signed [COL_W-1:0] w_loc_d;
  logic                    w_req_l_d, w_req_r_d;
  logic                    w_start_ok, w_one_req, w_last_row, w_row_fail;
  logic [3:0]              w_row_bits;
  logic [1:0]              w_rep;
  int                      w_tr, w_tc;

  assign w_start_ok = (r_state == StIdle) && io_bus.start;
  assign w_one_req  = r_req_l ^ r_req_r;
  assign w_last_row = (r_row == 2'd3);

`ifdef PIECE_SHIFT_AUTOREPEAT_EN
  localparam int CntW = $clog2(REPEAT_DELAY + 1);

  logic [1:0]      w_hold;
  logic [CntW-1:0] r_cnt [2];

  assign w_hold[0] = io_bus.move_left & ~io_bus.move_right;
  assign w_hold[1] = io_bus.move_right & ~io_bus.move_left;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      w_rep[d] = w_hold[d] & io_bus.tick & (r_cnt[d] == CntW'(REPEAT_DELAY - 1));
    end
  end

  // After the first repeat the counter restarts REPEAT_RATE ticks short of the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!w_hold[d]) begin
          r_cnt[d] <= '0;
        end else if (io_bus.tick) begin
          r_cnt[d] <= w_rep[d] ? CntW'(REPEAT_DELAY - REPEAT_RATE) : r_cnt[d] + CntW'(1);
        end
      end
    end
  end
`else
  localparam int unused_repeat = REPEAT_DELAY + REPEAT_RATE;
  logic w_unused_tick;
  assign w_unused_tick = io_bus.tick;
  assign w_rep = 2'b00;
`endif

  // Latches are consumed by an accepted start; presses arriving in that cycle survive.
  assign w_req_l_d = (w_start_ok ? 1'b0 : r_req_l) | io_bus.move_left | w_rep[0];
  assign w_req_r_d = (w_start_ok ? 1'b0 : r_req_r) | io_bus.move_right | w_rep[1];

  always_comb begin
    w_row_fail = 1'b0;
    w_tc       = 0;
    w_row_bits = r_mask[{r_row, 2'b00} +: 4];
    w_tr       = int'(r_anchor_row) - int'(r_row);
    for (int c = 0; c < 4; c++) begin
      w_tc = int'(r_anchor_col) + c + (r_dir_left ? -1 : 1);
      if (w_row_bits[c]) begin
        if (w_tc < 0 || w_tc >= BOARD_W || w_tr < 0) begin
          w_row_fail = 1'b1;
        end else if (w_tr < BOARD_H && io_bus.blocks_exist[IdxW'(w_tr * BOARD_W + w_tc)]) begin
          w_row_fail = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (io_bus.start && w_one_req) w_state_next = StCheck;
      StCheck:  if (w_last_row) w_state_next = StCommit;
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_busy_d    = (w_state_next == StCheck);
    w_done_d    = 1'b0;
    w_moved_d   = r_moved;
    w_blocked_d = r_blocked;
    w_loc_d     = r_loc_col;
    unique case (r_state)
      StIdle: begin
        // No request or both directions: answer immediately with the current column.
        if (io_bus.start && !w_one_req) begin
          w_done_d    = 1'b1;
          w_moved_d   = 1'b0;
          w_blocked_d = 1'b0;
          w_loc_d     = io_bus.anchor_col;
        end
      end
      StCheck: begin
        if (w_last_row) begin
          w_done_d = 1'b1;
          if (r_fail || w_row_fail) begin
            w_moved_d   = 1'b0;
            w_blocked_d = 1'b1;
            w_loc_d     = r_anchor_col;
          end else begin
            w_moved_d   = 1'b1;
            w_blocked_d = 1'b0;
            w_loc_d     = r_dir_left ? r_anchor_col - COL_W'(1) : r_anchor_col + COL_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      r_loc_col <= COL_W'(SPAWN_COL);
      r_req_l   <= 1'b0;
      r_req_r   <= 1'b0;
    end else begin
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_moved   <= w_moved_d;
      r_blocked <= w_blocked_d;
      r_loc_col <= w_loc_d;
      r_req_l   <= w_req_l_d;
      r_req_r   <= w_req_r_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= 2'd0;
      r_fail       <= 1'b0;
      r_dir_left   <= 1'b0;
      r_mask       <= '0;
      r_anchor_row <= '0;
      r_anchor_col <= '0;
    end else if (w_start_ok && w_one_req) begin
      r_row        <= 2'd0;
      r_fail       <= 1'b0;
      r_dir_left   <= r_req_l;
      r_mask       <= io_bus.piece_mask;
      r_anchor_row <= io_bus.anchor_row;
      r_anchor_col <= io_bus.anchor_col;
    end else if (r_state == StCheck) begin
      r_row  <= r_row + 2'd1;
      r_fail <= r_fail | w_row_fail;
    end
  end

  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.moved       = r_moved;
  assign io_bus.blocked     = r_blocked;
  assign io_bus.loc_col_out = r_loc_col;

endmodule

// File: tb/tb_piece_shift_engine.sv
// Directed bench for piece_shift_engine with a scoreboard of expected move results.
module tb_piece_shift_engine;

  typedef struct {
    logic        moved;
    logic        blocked;
    logic [31:0] col;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t sb[$];

  piece_shift_engine_if bus ();

  piece_shift_engine dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic l, input logic r);
    bus.move_left  = l;
    bus.move_right = r;
    step();
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int n0);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = n0;
    while (bus.done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".lat"}, n, e.lat);
    check({tag, ".moved"}, 32'(bus.moved), 32'(e.moved));
    check({tag, ".blocked"}, 32'(bus.blocked), 32'(e.blocked));
    check({tag, ".col"}, bus.loc_col_out, e.col);
  endtask

  task automatic run_start(input string tag, input logic m, input logic b, input int col,
                           input int lat);
    sb.push_back('{moved: m, blocked: b, col: col, lat: lat});
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (lat > 1) check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    wait_result(tag, 1);
  endtask

  initial begin
    logic seen_done;
    bus.move_left    = 1'b0;
    bus.move_right   = 1'b0;
    bus.tick         = 1'b0;
    bus.start        = 1'b0;
    bus.piece_mask   = 16'h0066;
    bus.anchor_row   = 6'd10;
    bus.anchor_col   = 6'sd3;
    bus.blocks_exist = '0;

    #12;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.moved", 32'(bus.moved), 32'd0);
    check("rst.blocked", 32'(bus.blocked), 32'd0);
    check("rst.col", bus.loc_col_out, 32'sd3);
    step();
    rst_n = 1'b1;
    step();

    // T1: O piece moves left on an empty board, then right
    press(1'b1, 1'b0);
    run_start("t1_left", 1'b1, 1'b0, 2, 5);
    press(1'b0, 1'b1);
    run_start("t1_right", 1'b1, 1'b0, 4, 5);

    // T2: walls
    bus.anchor_col = -6'sd1;
    press(1'b1, 1'b0);
    run_start("t2_lwall", 1'b0, 1'b1, -1, 5);
    bus.anchor_col = 6'sd7;
    press(1'b0, 1'b1);
    run_start("t2_rwall", 1'b0, 1'b1, 7, 5);

    // T3: I piece against a settled block, then with it removed
    bus.piece_mask       = 16'h000F;
    bus.anchor_row       = 6'd5;
    bus.anchor_col       = 6'sd5;
    bus.blocks_exist[59] = 1'b1;
    press(1'b0, 1'b1);
    run_start("t3_block", 1'b0, 1'b1, 5, 5);
    bus.blocks_exist[59] = 1'b0;
    press(1'b0, 1'b1);
    run_start("t3_clear", 1'b1, 1'b0, 6, 5);

    // Floor, rows above the board, and a hit found only in mask row 3
    bus.piece_mask = 16'h0F00;
    bus.anchor_row = 6'd1;
    bus.anchor_col = 6'sd3;
    press(1'b1, 1'b0);
    run_start("floor", 1'b0, 1'b1, 3, 5);
    bus.piece_mask   = 16'h000F;
    bus.anchor_row   = 6'd22;
    bus.blocks_exist = '1;
    press(1'b1, 1'b0);
    run_start("above", 1'b1, 1'b0, 2, 5);
    bus.blocks_exist     = '0;
    bus.blocks_exist[56] = 1'b1;
    bus.piece_mask       = 16'h8000;
    bus.anchor_row       = 6'd8;
    bus.anchor_col       = 6'sd2;
    press(1'b0, 1'b1);
    run_start("row3", 1'b0, 1'b1, 2, 5);

    // Empty mask never blocks, even on a full board at the right edge
    bus.piece_mask   = 16'h0000;
    bus.anchor_col   = 6'sd9;
    bus.blocks_exist = '1;
    press(1'b0, 1'b1);
    run_start("empty", 1'b1, 1'b0, 10, 5);
    bus.blocks_exist = '0;

    // T4: both directions cancel; latches must be clear afterwards
    bus.piece_mask = 16'h0066;
    bus.anchor_row = 6'd10;
    bus.anchor_col = 6'sd4;
    press(1'b1, 1'b1);
    run_start("t4_both", 1'b0, 1'b0, 4, 1);
    run_start("t4_after", 1'b0, 1'b0, 4, 1);

    // T5: right press and stray start during CHECK
    bus.anchor_col = 6'sd5;
    run_start("t5_noreq", 1'b0, 1'b0, 5, 1);
    bus.anchor_col = 6'sd4;
    press(1'b1, 1'b0);
    sb.push_back('{moved: 1'b1, blocked: 1'b0, col: 3, lat: 5});
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.move_right = 1'b1;
    bus.start      = 1'b1;
    step();
    bus.move_right = 1'b0;
    bus.start      = 1'b0;
    wait_result("t5_chk", 3);
    step();
    check("t5_nodone", 32'(bus.done), 32'd0);
    run_start("t5_kept", 1'b1, 1'b0, 5, 5);

    // T6: reset in the middle of CHECK
    press(1'b1, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6.busy", 32'(bus.busy), 32'd0);
    check("t6.done", 32'(bus.done), 32'd0);
    check("t6.moved", 32'(bus.moved), 32'd0);
    check("t6.col", bus.loc_col_out, 32'sd3);
    step();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_done = seen_done | bus.done;
    end
    check("t6.nodone", 32'(seen_done), 32'd0);
    run_start("t6_after", 1'b0, 1'b0, 4, 1);

`ifdef PIECE_SHIFT_AUTOREPEAT_EN
    bus.move_right = 1'b1;
    step();
    for (int t = 1; t <= 24; t++) begin
      logic fired;
      bus.tick = 1'b1;
      #1;
      fired = dut.w_rep[1];
      check($sformatf("rep%0d", t), 32'(fired), 32'((t == 16) || (t == 20) || (t == 24)));
      step();
      bus.tick = 1'b0;
      step();
    end
    bus.move_right = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
